// File: rtl/mer_pkg.sv
// Shared types and width helpers for the MER statistics engine.
package mer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDump
    } mer_state_e;

    function automatic int unsigned sq_acc_w(input int unsigned data_w,
                                             input int unsigned win_log2);
        return 2 * data_w + win_log2;
    endfunction

    function automatic int unsigned lin_acc_w(input int unsigned data_w,
                                              input int unsigned win_log2);
        return data_w + win_log2;
    endfunction

    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/mer_chan_accum.sv
// One channel's squared-error, DC-error and |dv| accumulators with window averaging.
module mer_chan_accum
    import mer_pkg::*;
#(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned WIN_LOG2 = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] e,
    input  logic signed [DATA_W-1:0] dv,
    output logic [2*DATA_W-1:0]      sq_mean,
    output logic signed [DATA_W-1:0] dc_mean,
    output logic [DATA_W-1:0]        pw_mean
);

    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned SqW   = sq_acc_w(DATA_W, WIN_LOG2);
    localparam int unsigned LinW  = lin_acc_w(DATA_W, WIN_LOG2);

    logic [SqW-1:0]          sq_q, sq_d;
    logic signed [LinW-1:0]  dc_q, dc_d;
    logic [LinW-1:0]         pw_q, pw_d;
    logic signed [ProdW-1:0] e_sq;
    logic [DATA_W-1:0]       dv_mag;

    always_comb begin
        e_sq   = ProdW'(e) * ProdW'(e);
        // Unsigned magnitude keeps |-2^(DATA_W-1)| exact.
        dv_mag = dv[DATA_W-1] ? (~$unsigned(dv) + 1'b1) : $unsigned(dv);
        sq_d   = sq_q;
        dc_d   = dc_q;
        pw_d   = pw_q;
        if (clear) begin
            sq_d = '0;
            dc_d = '0;
            pw_d = '0;
        end else if (enable) begin
            sq_d = sq_q + SqW'($unsigned(e_sq));
            dc_d = dc_q + LinW'(e);
            pw_d = pw_q + LinW'(dv_mag);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sq_q <= '0;
            dc_q <= '0;
            pw_q <= '0;
        end else begin
            sq_q <= sq_d;
            dc_q <= dc_d;
            pw_q <= pw_d;
        end
    end

    // Dropping the low bits is the divide; on dc it is a flooring arithmetic shift.
    assign sq_mean = sq_q[SqW-1:WIN_LOG2];
    assign dc_mean = dc_q[LinW-1:WIN_LOG2];
    assign pw_mean = pw_q[LinW-1:WIN_LOG2];

endmodule

// File: rtl/mer_stats_engine.sv
// MER statistics front end: enable generator, window FSM and per-channel result stream.
module mer_stats_engine
    import mer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned DIV      = 8,
    parameter int unsigned SPS      = 4,
    parameter int unsigned WIN_LOG2 = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       cont,
    input  logic [NUM_CH*DATA_W-1:0]   err_in,
    input  logic [NUM_CH*DATA_W-1:0]   dv_in,
    output logic                       smp_en,
    output logic                       sym_en,
    output logic                       win_start,
    output logic                       busy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ch_w(NUM_CH)-1:0]    res_ch,
    output logic [2*DATA_W-1:0]        res_sq_err,
    output logic [DATA_W-1:0]          res_dc_err,
    output logic [DATA_W-1:0]          res_map_pow
);

    localparam int unsigned ChW  = ch_w(NUM_CH);
    localparam int unsigned DivW = $clog2(DIV);
    localparam int unsigned SpsW = (SPS > 1) ? $clog2(SPS) : 1;

    localparam logic [DivW-1:0]     DivLast = DivW'(DIV - 1);
    localparam logic [SpsW-1:0]     SpsLast = SpsW'(SPS - 1);
    localparam logic [WIN_LOG2-1:0] WinLast = '1;
    localparam logic [ChW-1:0]      ChLast  = ChW'(NUM_CH - 1);

    mer_state_e          state_q, state_d;
    logic [DivW-1:0]     div_cnt_q, div_cnt_d;
    logic [SpsW-1:0]     smp_cnt_q, smp_cnt_d;
    logic [WIN_LOG2-1:0] sym_cnt_q, sym_cnt_d;
    logic [ChW-1:0]      k_q, k_d;
    logic                win_start_q;
    logic                acc_clear;
    logic                acc_en;

    logic [2*DATA_W-1:0]      sq_mean [NUM_CH];
    logic signed [DATA_W-1:0] dc_mean [NUM_CH];
    logic [DATA_W-1:0]        pw_mean [NUM_CH];

    // Free-running enables, independent of the FSM.
    assign smp_en = (div_cnt_q == DivLast);
    assign sym_en = smp_en && (smp_cnt_q == SpsLast);

    always_comb begin
        div_cnt_d = smp_en ? '0 : div_cnt_q + 1'b1;
        smp_cnt_d = smp_cnt_q;
        if (smp_en) begin
            smp_cnt_d = (smp_cnt_q == SpsLast) ? '0 : smp_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        sym_cnt_d = sym_cnt_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAccum;
                    acc_clear = 1'b1;
                    sym_cnt_d = '0;
                end
            end
            StAccum: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (sym_en) begin
                    acc_en    = 1'b1;
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (sym_cnt_q == WinLast) begin
                        state_d = StDump;
                        k_d     = '0;
                    end
                end
            end
            StDump: begin
                if (res_ready) begin
                    if (k_q == ChLast) begin
                        k_d = '0;
                        if (cont) begin
                            state_d   = StAccum;
                            acc_clear = 1'b1;
                            sym_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            k_q         <= '0;
            win_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            k_q         <= k_d;
            win_start_q <= acc_clear;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mer_chan_accum #(
            .DATA_W   (DATA_W),
            .WIN_LOG2 (WIN_LOG2)
        ) u_accum (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .clear    (acc_clear),
            .enable   (acc_en),
            .e        (err_in[k*DATA_W +: DATA_W]),
            .dv       (dv_in[k*DATA_W +: DATA_W]),
            .sq_mean  (sq_mean[k]),
            .dc_mean  (dc_mean[k]),
            .pw_mean  (pw_mean[k])
        );
    end

    assign win_start   = win_start_q;
    assign busy        = (state_q != StIdle);
    assign res_valid   = (state_q == StDump);
    assign res_ch      = k_q;
    assign res_sq_err  = sq_mean[k_q];
    assign res_dc_err  = dc_mean[k_q];
    assign res_map_pow = pw_mean[k_q];

endmodule
